ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Consumer end of the decoded control bundle: the bundle {branch, MemRead, MemtoReg, ALUOp[1:0], MemWrite, ALUSrc, RegWrite, WB[1:0]} (10 bits, MSB first) enters from the ID stage.
- The block carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers and presents per-stage control to the datapath.
- It also detects load-use hazards (stall), applies branch flushes and generates forwarding selects for the EX-stage ALU operands.

Parameters:
- REG_AW, 5, register-address width.
- CTRL_W, 10, control bundle width; field order fixed as listed in Overview.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_ctrl  in  CTRL_W  decoded control bundle.
- id_rs1, id_rs2, id_rd  in  REG_AW  register addresses of the ID instruction.
- flush  in  1  branch/jump taken, resolved in MEM.
- hold  in  1  external freeze (e.g. memory busy).
- stall  out  1  load-use hazard; fetch/ID must hold PC and IF/ID.
- ex_ALUOp  out  2  ALUOp for the EX stage.
- ex_ALUSrc  out  1  ALUSrc for the EX stage.
- ex_rs1, ex_rs2  out  REG_AW  EX-stage source register addresses.
- fwd_a, fwd_b  out  2  operand select: 00 regfile, 10 from EX/MEM, 01 from MEM/WB.
- mem_branch, mem_MemRead, mem_MemWrite  out  1 each  MEM-stage controls.
- mem_rd  out  REG_AW  EX/MEM destination register.
- wb_MemtoReg, wb_RegWrite  out  1 each  WB-stage controls.
- wb_sel  out  2  WB field for the WB stage.
- wb_rd  out  REG_AW  MEM/WB destination register.

Behaviour:
- State: three register sets.
  - ID/EX: {v, ctrl[9:0], rs1, rs2, rd}.
  - EX/MEM: {v, branch, MemRead, MemWrite, MemtoReg, RegWrite, WB, rd}.
  - MEM/WB: {v, MemtoReg, RegWrite, WB, rd}.
- Bubble: v=0 with all control bits 0. Stage outputs come directly from the registers, so a bubble drives 0 on every control output.
- Reset: rst high clears all three sets to bubble with addresses 0, immediately (asynchronous). Consequently every output is 0 during and after reset, including stall, fwd_a and fwd_b.
- Normal advance: latency is 1 cycle per stage. An instruction captured at edge N appears on ex_* after N, mem_* after N+1 and wb_* after N+2. When id_valid=0, ID/EX loads a bubble.
- stall (combinational) is high when all of the following hold:
  - id_valid & IDEX.v & IDEX.MemRead;
  - IDEX.rd != 0;
  - IDEX.rd == id_rs1, or IDEX.rd == id_rs2.
- On stall: ID/EX loads a bubble, while EX/MEM and MEM/WB advance normally. The stalled ID instruction is re-presented by upstream next cycle. A stall resolves after exactly 1 cycle.
- On flush: ID/EX and EX/MEM load bubbles, and MEM/WB captures the current EX/MEM contents. The flushing jump therefore still writes back (JAL/JALR RegWrite=1). The stall output is ignored on a flush cycle.
- Priority per edge: rst > hold > flush > stall > normal.
- hold=1 freezes all three register sets, and a flush arriving during hold is ignored. The flush requester keeps flush asserted until hold is low; stall stays combinationally valid.
- Forwarding, evaluated against IDEX.rs1 (fwd_a) and IDEX.rs2 (fwd_b):
  - 10 if EXMEM.v & EXMEM.RegWrite & EXMEM.rd != 0 & the addresses match;
  - otherwise 01 under the same conditions on MEM/WB;
  - otherwise 00.
  - EX/MEM wins when both stages match.
- Register x0 never causes a stall or a forward.
- Don't-care (X) bits in id_ctrl are registered unchanged. Only v-qualified branch, MemRead, MemWrite and RegWrite feed the hazard, forwarding and flush logic, so X never reaches stall or fwd_a/fwd_b.

Decomposition:
- Shared package (defines): CTRL_W and the bundle field bit positions (CTRL_BRANCH=9, CTRL_MEMREAD=8, CTRL_MEMTOREG=7, CTRL_ALUOP=6:5, CTRL_MEMWRITE=4, CTRL_ALUSRC=3, CTRL_REGWRITE=2, CTRL_WB=1:0), plus the forwarding select constants FWD_RF, FWD_EXMEM, FWD_MEMWB.
- One sub-module, fwd_unit: purely combinational, instantiated once. Inputs are the EX/MEM and MEM/WB {v, RegWrite, rd} and the ID/EX rs1/rs2; outputs are fwd_a/fwd_b.
- The pipeline registers and hazard logic stay in ctrl_pipe.

Test Plan:
- Reset and pass-through: assert rst mid-run → all outputs 0 asynchronously. Then release rst and send an R-type (ctrl 10'b000_10_001_00, rd=5) → ex_ALUOp=10 after edge 1, mem_rd=5 after edge 2, wb_RegWrite=1 with wb_rd=5 after edge 3.
- Load-use: send a load (rd=7, MemRead=1), then an add with rs1=7 → stall=1 for exactly one cycle and ex_* shows a bubble. The add then enters with fwd_a=01 once the load reaches MEM/WB. Same sequence with rd=0 → stall stays 0.
- Forwarding priority: back-to-back writes to x3, then a reader of x3 in both rs1 and rs2 → fwd_a=fwd_b=10. With one intervening bubble instead → 01.
- Flush: JAL (branch=1, RegWrite=1, rd=1) reaches MEM with flush=1 → next cycle ID/EX and EX/MEM are bubbles, and wb_RegWrite=1 with wb_rd=1.
- Hold: hold=1 for 3 cycles with a flush pulse inside the hold window → all outputs frozen and the flush has no effect. Flush re-asserted after hold drops → it is applied.
- Simultaneous: stall and flush in the same cycle → flush behaviour wins; the next cycle shows ID/EX=bubble and EX/MEM=bubble.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - control bundle layout, forwarding selects and pipeline register types
package ctrl_pipe_pkg;

    localparam int REG_AW = 5;
    localparam int CTRL_W = 10;

    localparam int CTRL_BRANCH   = 9;
    localparam int CTRL_MEMREAD  = 8;
    localparam int CTRL_MEMTOREG = 7;
    localparam int CTRL_ALUOP_HI = 6;
    localparam int CTRL_ALUOP_LO = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_WB_HI    = 1;
    localparam int CTRL_WB_LO    = 0;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic              v;
        logic [CTRL_W-1:0] ctrl;
        reg_addr_t         rs1;
        reg_addr_t         rs2;
        reg_addr_t         rd;
    } idex_t;

    typedef struct packed {
        logic       v;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic [1:0] wb;
        reg_addr_t  rd;
    } exmem_t;

    typedef struct packed {
        logic       v;
        logic       memtoreg;
        logic       regwrite;
        logic [1:0] wb;
        reg_addr_t  rd;
    } memwb_t;

endpackage

// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - ID-stage inputs and per-stage control outputs of ctrl_pipe
interface ctrl_pipe_if;
    import ctrl_pipe_pkg::*;

    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    reg_addr_t         id_rs1;
    reg_addr_t         id_rs2;
    reg_addr_t         id_rd;
    logic              flush;
    logic              hold;

    logic              stall;
    logic [1:0]        ex_ALUOp;
    logic              ex_ALUSrc;
    reg_addr_t         ex_rs1;
    reg_addr_t         ex_rs2;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              mem_branch;
    logic              mem_MemRead;
    logic              mem_MemWrite;
    reg_addr_t         mem_rd;
    logic              wb_MemtoReg;
    logic              wb_RegWrite;
    logic [1:0]        wb_sel;
    reg_addr_t         wb_rd;

    modport master (
        output id_valid, id_ctrl, id_rs1, id_rs2, id_rd, flush, hold,
        input  stall, ex_ALUOp, ex_ALUSrc, ex_rs1, ex_rs2, fwd_a, fwd_b,
        input  mem_branch, mem_MemRead, mem_MemWrite, mem_rd,
        input  wb_MemtoReg, wb_RegWrite, wb_sel, wb_rd
    );

    modport slave (
        input  id_valid, id_ctrl, id_rs1, id_rs2, id_rd, flush, hold,
        output stall, ex_ALUOp, ex_ALUSrc, ex_rs1, ex_rs2, fwd_a, fwd_b,
        output mem_branch, mem_MemRead, mem_MemWrite, mem_rd,
        output wb_MemtoReg, wb_RegWrite, wb_sel, wb_rd
    );

endinterface

// File: rtl/ctrl_pipe_fwd_unit.sv
// rtl/ctrl_pipe_fwd_unit.sv - EX-stage operand forwarding selects
module fwd_unit
    import ctrl_pipe_pkg::*;
(
    input  logic       exmem_v,
    input  logic       exmem_regwrite,
    input  reg_addr_t  exmem_rd,
    input  logic       memwb_v,
    input  logic       memwb_regwrite,
    input  reg_addr_t  memwb_rd,
    input  reg_addr_t  idex_rs1,
    input  reg_addr_t  idex_rs2,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic em_ok;
    logic mw_ok;

    // x0 is hardwired zero, so a pending write to it must never be forwarded
    assign em_ok = exmem_v & exmem_regwrite & (exmem_rd != '0);
    assign mw_ok = memwb_v & memwb_regwrite & (memwb_rd != '0);

    assign fwd_a = (em_ok && (exmem_rd == idex_rs1)) ? FWD_EXMEM :
                   (mw_ok && (memwb_rd == idex_rs1)) ? FWD_MEMWB : FWD_RF;
    assign fwd_b = (em_ok && (exmem_rd == idex_rs2)) ? FWD_EXMEM :
                   (mw_ok && (memwb_rd == idex_rs2)) ? FWD_MEMWB : FWD_RF;

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX, EX/MEM, MEM/WB control registers with load-use stall and branch flush
module ctrl_pipe
    import ctrl_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    ctrl_pipe_if.slave  bus
);

    idex_t  idex;
    idex_t  idex_load;
    exmem_t exmem;
    exmem_t exmem_load;
    memwb_t memwb;
    memwb_t memwb_load;
    logic   stall;

    assign stall = bus.id_valid & idex.v & idex.ctrl[CTRL_MEMREAD] & (idex.rd != '0) &
                   ((idex.rd == bus.id_rs1) | (idex.rd == bus.id_rs2));

    always_comb begin
        idex_load = '0;
        if (bus.id_valid && !stall) begin
            idex_load.v    = 1'b1;
            idex_load.ctrl = bus.id_ctrl;
            idex_load.rs1  = bus.id_rs1;
            idex_load.rs2  = bus.id_rs2;
            idex_load.rd   = bus.id_rd;
        end
    end

    // Fields are v-qualified so a bubble carries all-zero control downstream
    always_comb begin
        exmem_load = '0;
        if (idex.v) begin
            exmem_load.v        = 1'b1;
            exmem_load.branch   = idex.ctrl[CTRL_BRANCH];
            exmem_load.memread  = idex.ctrl[CTRL_MEMREAD];
            exmem_load.memwrite = idex.ctrl[CTRL_MEMWRITE];
            exmem_load.memtoreg = idex.ctrl[CTRL_MEMTOREG];
            exmem_load.regwrite = idex.ctrl[CTRL_REGWRITE];
            exmem_load.wb       = idex.ctrl[CTRL_WB_HI:CTRL_WB_LO];
            exmem_load.rd       = idex.rd;
        end
    end

    always_comb begin
        memwb_load = '0;
        if (exmem.v) begin
            memwb_load.v        = 1'b1;
            memwb_load.memtoreg = exmem.memtoreg;
            memwb_load.regwrite = exmem.regwrite;
            memwb_load.wb       = exmem.wb;
            memwb_load.rd       = exmem.rd;
        end
    end

    // A flush kills the two younger stages but lets the branch itself retire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else if (!bus.hold) begin
            memwb <= memwb_load;
            if (bus.flush) begin
                idex  <= '0;
                exmem <= '0;
            end else begin
                idex  <= idex_load;
                exmem <= exmem_load;
            end
        end
    end

    fwd_unit u_fwd (
        .exmem_v        (exmem.v),
        .exmem_regwrite (exmem.regwrite),
        .exmem_rd       (exmem.rd),
        .memwb_v        (memwb.v),
        .memwb_regwrite (memwb.regwrite),
        .memwb_rd       (memwb.rd),
        .idex_rs1       (idex.rs1),
        .idex_rs2       (idex.rs2),
        .fwd_a          (bus.fwd_a),
        .fwd_b          (bus.fwd_b)
    );

    assign bus.stall        = stall;
    assign bus.ex_ALUOp     = idex.ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
    assign bus.ex_ALUSrc    = idex.ctrl[CTRL_ALUSRC];
    assign bus.ex_rs1       = idex.rs1;
    assign bus.ex_rs2       = idex.rs2;
    assign bus.mem_branch   = exmem.branch;
    assign bus.mem_MemRead  = exmem.memread;
    assign bus.mem_MemWrite = exmem.memwrite;
    assign bus.mem_rd       = exmem.rd;
    assign bus.wb_MemtoReg  = memwb.memtoreg;
    assign bus.wb_RegWrite  = memwb.regwrite;
    assign bus.wb_sel       = memwb.wb;
    assign bus.wb_rd        = memwb.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - scoreboard bench for ctrl_pipe: directed vectors, negedge monitor
module tb_ctrl_pipe;

    localparam int F_STALL = 0,  F_EXALUOP = 1, F_EXALUSRC = 2, F_EXRS1 = 3, F_EXRS2 = 4;
    localparam int F_FWDA  = 5,  F_FWDB = 6,    F_MBR = 7,      F_MMR = 8,   F_MMW = 9;
    localparam int F_MRD   = 10, F_WMTR = 11,   F_WRW = 12,     F_WSEL = 13, F_WRD = 14;
    localparam int F_ALL   = 15;

    // {branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite, WB}
    localparam logic [9:0] C_R   = 10'b0001000100;
    localparam logic [9:0] C_LD  = 10'b0110001101;
    localparam logic [9:0] C_JAL = 10'b1000000110;

    typedef struct {
        int          cyc;
        int          fld;
        logic [63:0] val;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   passed;
    exp_t sb[$];

    ctrl_pipe_if bus ();

    ctrl_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] field(input int f);
        logic [63:0] r;
        r = '0;
        case (f)
            F_STALL:    r[0]   = bus.stall;
            F_EXALUOP:  r[1:0] = bus.ex_ALUOp;
            F_EXALUSRC: r[0]   = bus.ex_ALUSrc;
            F_EXRS1:    r[4:0] = bus.ex_rs1;
            F_EXRS2:    r[4:0] = bus.ex_rs2;
            F_FWDA:     r[1:0] = bus.fwd_a;
            F_FWDB:     r[1:0] = bus.fwd_b;
            F_MBR:      r[0]   = bus.mem_branch;
            F_MMR:      r[0]   = bus.mem_MemRead;
            F_MMW:      r[0]   = bus.mem_MemWrite;
            F_MRD:      r[4:0] = bus.mem_rd;
            F_WMTR:     r[0]   = bus.wb_MemtoReg;
            F_WRW:      r[0]   = bus.wb_RegWrite;
            F_WSEL:     r[1:0] = bus.wb_sel;
            F_WRD:      r[4:0] = bus.wb_rd;
            default:    r[34:0] = {bus.stall, bus.ex_ALUOp, bus.ex_ALUSrc, bus.ex_rs1, bus.ex_rs2,
                                   bus.fwd_a, bus.fwd_b, bus.mem_branch, bus.mem_MemRead,
                                   bus.mem_MemWrite, bus.mem_rd, bus.wb_MemtoReg, bus.wb_RegWrite,
                                   bus.wb_sel, bus.wb_rd};
        endcase
        return r;
    endfunction

    // Monitor: compare every expectation queued for the current cycle
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] a;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            a = field(e.fld);
            checks = checks + 1;
            if (e.cyc == cyc && a === e.val)
                passed = passed + 1;
            else
                $display("FAIL %s cyc=%0d got=%0h want=%0h (queued for cyc %0d)",
                         e.name, cyc, a, e.val, e.cyc);
        end
    end

    task automatic expect_out(input int f, input logic [63:0] v, input string n);
        exp_t e;
        e.cyc  = cyc;
        e.fld  = f;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic put(input logic v, input logic [9:0] c, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] d, input logic fl, input logic hd);
        bus.id_valid = v;
        bus.id_ctrl  = c;
        bus.id_rs1   = s1;
        bus.id_rs2   = s2;
        bus.id_rd    = d;
        bus.flush    = fl;
        bus.hold     = hd;
    endtask

    task automatic idle();
        put(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        passed = 0;
        rst    = 1'b1;
        idle();
        tick();
        tick();
        expect_out(F_ALL, 64'd0, "reset_state");
        tick();
        rst = 1'b0;

        // pass-through of an R-type
        put(1'b1, C_R, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
        tick();
        idle();
        expect_out(F_EXALUOP, 64'd2, "rtype_ex_aluop");
        expect_out(F_EXRS1, 64'd1, "rtype_ex_rs1");
        tick();
        put(1'b1, C_R, 5'd3, 5'd4, 5'd6, 1'b0, 1'b0);
        expect_out(F_MRD, 64'd5, "rtype_mem_rd");
        expect_out(F_EXALUOP, 64'd0, "idle_bubble_aluop");
        tick();
        put(1'b1, C_LD, 5'd2, 5'd0, 5'd9, 1'b0, 1'b0);
        expect_out(F_WRW, 64'd1, "rtype_wb_regwrite");
        expect_out(F_WRD, 64'd5, "rtype_wb_rd");
        expect_out(F_EXRS1, 64'd3, "second_r_ex_rs1");
        tick();
        rst = 1'b1;
        idle();
        expect_out(F_ALL, 64'd0, "async_reset_midcycle");
        tick();
        expect_out(F_ALL, 64'd0, "reset_held");
        tick();
        rst = 1'b0;

        // load-use stall through rs1, then forward from MEM/WB
        put(1'b1, C_LD, 5'd2, 5'd0, 5'd7, 1'b0, 1'b0);
        tick();
        put(1'b1, C_R, 5'd7, 5'd3, 5'd8, 1'b0, 1'b0);
        expect_out(F_STALL, 64'd1, "loaduse_stall");
        expect_out(F_EXALUSRC, 64'd1, "load_in_ex");
        tick();
        put(1'b1, C_R, 5'd7, 5'd3, 5'd8, 1'b0, 1'b0);
        expect_out(F_STALL, 64'd0, "stall_one_cycle");
        expect_out(F_EXALUOP, 64'd0, "stall_bubble_aluop");
        expect_out(F_EXALUSRC, 64'd0, "stall_bubble_alusrc");
        expect_out(F_MMR, 64'd1, "load_in_mem");
        expect_out(F_MRD, 64'd7, "load_mem_rd");
        tick();
        idle();
        expect_out(F_EXALUOP, 64'd2, "add_enters_ex");
        expect_out(F_EXRS1, 64'd7, "add_ex_rs1");
        expect_out(F_FWDA, 64'd1, "loaduse_fwd_a_memwb");
        expect_out(F_FWDB, 64'd0, "loaduse_fwd_b_rf");
        expect_out(F_WMTR, 64'd1, "load_wb_memtoreg");
        tick();

        // load to x0 never stalls or forwards
        put(1'b1, C_LD, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        put(1'b1, C_R, 5'd0, 5'd4, 5'd8, 1'b0, 1'b0);
        expect_out(F_STALL, 64'd0, "x0_no_stall");
        tick();
        idle();
        expect_out(F_EXALUOP, 64'd2, "x0_add_enters");
        expect_out(F_FWDA, 64'd0, "x0_no_fwd");
        tick();

        // load-use through rs2
        put(1'b1, C_LD, 5'd2, 5'd0, 5'd4, 1'b0, 1'b0);
        tick();
        put(1'b1, C_R, 5'd1, 5'd4, 5'd8, 1'b0, 1'b0);
        expect_out(F_STALL, 64'd1, "stall_via_rs2");
        tick();
        put(1'b1, C_R, 5'd1, 5'd4, 5'd8, 1'b0, 1'b0);
        expect_out(F_STALL, 64'd0, "rs2_stall_released");
        tick();
        idle();
        expect_out(F_FWDB, 64'd1, "rs2_fwd_memwb");
        tick();

        // forwarding priority: EX/MEM beats MEM/WB
        put(1'b1, C_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        tick();
        put(1'b1, C_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        tick();
        put(1'b1, C_R, 5'd3, 5'd3, 5'd9, 1'b0, 1'b0);
        tick();
        idle();
        expect_out(F_FWDA, 64'd2, "fwd_a_exmem_prio");
        expect_out(F_FWDB, 64'd2, "fwd_b_exmem_prio");
        tick();
        put(1'b1, C_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        put(1'b1, C_R, 5'd3, 5'd3, 5'd9, 1'b0, 1'b0);
        tick();
        idle();
        expect_out(F_FWDA, 64'd1, "fwd_a_memwb_gap");
        expect_out(F_FWDB, 64'd1, "fwd_b_memwb_gap");
        tick();

        // flush with JAL in MEM
        put(1'b1, C_JAL, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
        tick();
        put(1'b1, C_R, 5'd1, 5'd2, 5'd2, 1'b0, 1'b0);
        tick();
        put(1'b1, C_R, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);
        expect_out(F_MBR, 64'd1, "jal_in_mem");
        expect_out(F_MRD, 64'd1, "jal_mem_rd");
        tick();
        idle();
        expect_out(F_EXALUOP, 64'd0, "flush_idex_aluop");
        expect_out(F_EXRS1, 64'd0, "flush_idex_rs1");
        expect_out(F_MBR, 64'd0, "flush_exmem_branch");
        expect_out(F_MRD, 64'd0, "flush_exmem_rd");
        expect_out(F_WRW, 64'd1, "flush_jal_regwrite");
        expect_out(F_WRD, 64'd1, "flush_jal_wb_rd");
        expect_out(F_WSEL, 64'd2, "flush_jal_wb_sel");
        tick();

        // hold for three edges with a flush pulse inside, flush re-asserted afterwards
        put(1'b1, C_LD, 5'd2, 5'd0, 5'd10, 1'b0, 1'b0);
        tick();
        put(1'b1, C_JAL, 5'd0, 5'd0, 5'd11, 1'b0, 1'b0);
        tick();
        put(1'b1, C_R, 5'd13, 5'd14, 5'd12, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            put(1'b1, C_R, 5'd1, 5'd2, 5'd20, (i == 1), 1'b1);
            expect_out(F_EXALUOP, 64'd2, "hold_ex_aluop");
            expect_out(F_EXRS1, 64'd13, "hold_ex_rs1");
            expect_out(F_MBR, 64'd1, "hold_mem_branch");
            expect_out(F_MRD, 64'd11, "hold_mem_rd");
            expect_out(F_WRD, 64'd10, "hold_wb_rd");
            expect_out(F_WMTR, 64'd1, "hold_wb_memtoreg");
            tick();
        end
        put(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        expect_out(F_MRD, 64'd11, "hold_released_mem_rd");
        expect_out(F_WRD, 64'd10, "hold_released_wb_rd");
        tick();
        idle();
        expect_out(F_EXALUOP, 64'd0, "post_hold_flush_ex");
        expect_out(F_MBR, 64'd0, "post_hold_flush_mem_branch");
        expect_out(F_MRD, 64'd0, "post_hold_flush_mem_rd");
        expect_out(F_WRD, 64'd11, "post_hold_jal_wb_rd");
        expect_out(F_WSEL, 64'd2, "post_hold_jal_wb_sel");
        tick();

        // stall and flush together: flush wins
        put(1'b1, C_JAL, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
        tick();
        put(1'b1, C_LD, 5'd2, 5'd0, 5'd6, 1'b0, 1'b0);
        tick();
        put(1'b1, C_R, 5'd6, 5'd3, 5'd8, 1'b1, 1'b0);
        expect_out(F_STALL, 64'd1, "stall_with_flush");
        expect_out(F_MBR, 64'd1, "sim_jal_in_mem");
        tick();
        idle();
        expect_out(F_EXALUSRC, 64'd0, "sim_idex_bubble");
        expect_out(F_MMR, 64'd0, "sim_exmem_bubble_memread");
        expect_out(F_MRD, 64'd0, "sim_exmem_bubble_rd");
        expect_out(F_WRW, 64'd1, "sim_jal_wb_regwrite");
        expect_out(F_WRD, 64'd1, "sim_jal_wb_rd");
        tick();
        tick();

        checks = checks + 1;
        if (sb.size() == 0)
            passed = passed + 1;
        else
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
